// File: rtl/sevseg_pkg.sv
// Shared definitions for the seven-segment display driver: segment bit layout
// and the active-high hex glyph table.
package sevseg_pkg;

    localparam int SEG_W = 7;

    typedef enum int {
        SEG_A = 0,
        SEG_B = 1,
        SEG_C = 2,
        SEG_D = 3,
        SEG_E = 4,
        SEG_F = 5,
        SEG_G = 6
    } segBit_e;

    typedef logic [SEG_W-1:0] segments_t;

    // Bit order {g,f,e,d,c,b,a}; a bit set means the segment is lit.
    localparam segments_t GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h67, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic segments_t glyphOf(input logic [3:0] nibble);
        return GLYPH_TABLE[nibble];
    endfunction

endpackage

// File: rtl/sevseg_glyph.sv
// Combinational hex nibble to active-high seven-segment pattern.
module sevseg_glyph
    import sevseg_pkg::*;
(
    input  logic [3:0]       i_nibble,
    output logic [SEG_W-1:0] o_segments
);

    assign o_segments = glyphOf(i_nibble);

endmodule

// File: rtl/sevseg_scan_driver.sv
// Multiplexed N-digit seven-segment scan driver with leading-zero blanking,
// per-digit decimal points and value updates committed only at frame boundaries.
module sevseg_scan_driver
    import sevseg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1,
    parameter int LZ_BLANK       = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_load,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic [NUM_DIGITS-1:0]   i_dp_in,
    output logic [SEG_W-1:0]        o_seg,
    output logic                    o_dp,
    output logic [NUM_DIGITS-1:0]   o_dig_en,
    output logic                    o_frame_done
);

    localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic                 SEG_INV    = (SEG_ACTIVE_LOW != 0);
    localparam logic                 DIG_INV    = (DIG_ACTIVE_LOW != 0);
    localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SEG_W-1:0]     SEG_OFF    = {SEG_W{SEG_INV}};
    localparam logic [NUM_DIGITS-1:0] DIG_OFF   = {NUM_DIGITS{DIG_INV}};

    logic [PRESC_W-1:0]      r_prescaler;
    logic [IDX_W-1:0]        r_digitIdx;
    logic [4*NUM_DIGITS-1:0] r_shadowValue;
    logic [NUM_DIGITS-1:0]   r_shadowDp;
    logic [4*NUM_DIGITS-1:0] r_dispValue;
    logic [NUM_DIGITS-1:0]   r_dispDp;
    logic                    r_pending;
    logic                    r_wrapped;
    logic [SEG_W-1:0]        r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_digEn;
    logic                    r_frameDone;

    logic                    w_digitLast;
    logic                    w_frameEnd;
    logic [3:0]              w_curNibble;
    logic                    w_curDp;
    logic                    w_curBlank;
    logic                    w_zeroAbove;
    logic [NUM_DIGITS-1:0]   w_digOneHot;
    logic [SEG_W-1:0]        w_glyphSeg;
    logic [SEG_W-1:0]        w_segOn;

    assign w_digitLast = (r_prescaler == PRESC_LAST);
    assign w_frameEnd  = w_digitLast && (r_digitIdx == IDX_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prescaler <= '0;
            r_digitIdx  <= '0;
            r_wrapped   <= 1'b0;
        end else begin
            r_wrapped <= w_frameEnd;
            if (w_digitLast) begin
                r_prescaler <= '0;
                r_digitIdx  <= w_frameEnd ? '0 : r_digitIdx + IDX_W'(1);
            end else begin
                r_prescaler <= r_prescaler + PRESC_W'(1);
            end
        end
    end

    // A load landing on the boundary cycle bypasses the shadow so it is not
    // held back a whole extra frame.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shadowValue <= '0;
            r_shadowDp    <= '0;
            r_dispValue   <= '0;
            r_dispDp      <= '0;
            r_pending     <= 1'b0;
        end else if (w_frameEnd) begin
            if (i_load) begin
                r_dispValue <= i_value;
                r_dispDp    <= i_dp_in;
            end else if (r_pending) begin
                r_dispValue <= r_shadowValue;
                r_dispDp    <= r_shadowDp;
            end
            r_pending <= 1'b0;
        end else if (i_load) begin
            r_shadowValue <= i_value;
            r_shadowDp    <= i_dp_in;
            r_pending     <= 1'b1;
        end
    end

    // Walk from the top digit down so each digit knows whether everything
    // above and including it is zero.
    always_comb begin
        w_curNibble = 4'h0;
        w_curDp     = 1'b0;
        w_curBlank  = 1'b0;
        w_digOneHot = '0;
        w_zeroAbove = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_zeroAbove = w_zeroAbove && (r_dispValue[4*k +: 4] == 4'h0);
            if (r_digitIdx == IDX_W'(k)) begin
                w_curNibble    = r_dispValue[4*k +: 4];
                w_curDp        = r_dispDp[k];
                w_curBlank     = (LZ_BLANK != 0) && (k > 0) && w_zeroAbove;
                w_digOneHot[k] = 1'b1;
            end
        end
    end

    sevseg_glyph u_glyph (
        .i_nibble   (w_curNibble),
        .o_segments (w_glyphSeg)
    );

    assign w_segOn = w_curBlank ? '0 : w_glyphSeg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_seg       <= SEG_OFF;
            r_dp        <= SEG_INV;
            r_digEn     <= DIG_OFF;
            r_frameDone <= 1'b0;
        end else begin
            r_seg       <= w_segOn ^ SEG_OFF;
            r_dp        <= w_curDp ^ SEG_INV;
            r_digEn     <= w_digOneHot ^ DIG_OFF;
            r_frameDone <= r_wrapped;
        end
    end

    assign o_seg        = r_seg;
    assign o_dp         = r_dp;
    assign o_dig_en     = r_digEn;
    assign o_frame_done = r_frameDone;

endmodule

// File: tb/tb_sevseg_scan_driver.sv
// Self-checking bench for sevseg_scan_driver: literal vector table, directed
// frame-boundary sequences and randomized traffic against a timeline model.
module tb_sevseg_scan_driver;

    localparam int NUM_DIGITS = 4;
    localparam int SCAN_DIV   = 4;
    localparam int FRAME      = NUM_DIGITS * SCAN_DIV;
    localparam int NUM_VECS   = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dpIn;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  digEn;
    logic        frameDone;

    always #5 clk = ~clk;

    sevseg_scan_driver #(
        .NUM_DIGITS     (NUM_DIGITS),
        .SCAN_DIV       (SCAN_DIV),
        .SEG_ACTIVE_LOW (1),
        .DIG_ACTIVE_LOW (1),
        .LZ_BLANK       (1)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_load       (load),
        .i_value      (value),
        .i_dp_in      (dpIn),
        .o_seg        (seg),
        .o_dp         (dp),
        .o_dig_en     (digEn),
        .o_frame_done (frameDone)
    );

    typedef struct {
        int          edgeNum;
        logic [15:0] value;
        logic [3:0]  dp;
    } loadRec_t;

    typedef struct {
        logic [15:0]     value;
        logic [3:0]      dpIn;
        logic [3:0][6:0] expSeg;
        logic [3:0]      expDp;
    } vector_t;

    loadRec_t   loadHistory [$];
    vector_t    vecs [NUM_VECS];
    int         modelEdge = 0;
    int         checks = 0;
    int         errors = 0;
    logic [6:0] glyphRef [16];
    string      glyphNames [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                                    "acdefg", "abc", "abcdefg", "abcfg", "abcefg",
                                    "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    // Reference glyphs are built from segment-letter names, not hex constants.
    function automatic logic [6:0] segmentsFromName(input string name);
        logic [6:0] bits;
        bits = '0;
        for (int i = 0; i < name.len(); i++) begin
            bits[int'(name[i]) - 97] = 1'b1;
        end
        return bits;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // The value on screen during a frame is the last load sampled at or before
    // the edge that started that frame.
    function automatic logic [19:0] displayedAt(input int s);
        int         boundary;
        logic [19:0] result;
        boundary = (s / FRAME) * FRAME;
        result = '0;
        if (boundary > 0) begin
            foreach (loadHistory[i]) begin
                if (loadHistory[i].edgeNum <= boundary)
                    result = {loadHistory[i].dp, loadHistory[i].value};
            end
        end
        return result;
    endfunction

    task automatic checkOutput();
        logic [6:0]  expSeg;
        logic        expDp;
        logic [3:0]  expDig;
        logic        expFd;
        logic [19:0] shown;
        logic [15:0] upper;
        logic [3:0]  nibble;
        logic [6:0]  lit;
        int          s;
        int          digit;
        if (modelEdge == 0) begin
            expSeg = 7'h7F;
            expDp  = 1'b1;
            expDig = 4'hF;
            expFd  = 1'b0;
        end else begin
            s      = modelEdge - 1;
            digit  = (s / SCAN_DIV) % NUM_DIGITS;
            shown  = displayedAt(s);
            nibble = shown[4*digit +: 4];
            upper  = shown[15:0] >> (4 * digit);
            lit    = (digit > 0 && upper == 16'h0) ? 7'h00 : glyphRef[nibble];
            expSeg = ~lit;
            expDp  = ~shown[16 + digit];
            expDig = ~(4'b0001 << digit);
            expFd  = (s % FRAME == 0) && (s > 0);
        end
        checkValue($sformatf("model seg @%0d", modelEdge), 32'(seg), 32'(expSeg));
        checkValue($sformatf("model dp @%0d", modelEdge), 32'(dp), 32'(expDp));
        checkValue($sformatf("model dig_en @%0d", modelEdge), 32'(digEn), 32'(expDig));
        checkValue($sformatf("model frame_done @%0d", modelEdge), 32'(frameDone), 32'(expFd));
    endtask

    task automatic applyStimulus(input logic r, input logic l, input logic [15:0] v,
                                 input logic [3:0] d);
        rst   = r;
        load  = l;
        value = v;
        dpIn  = d;
        @(posedge clk);
        if (r) begin
            modelEdge = 0;
            loadHistory.delete();
        end else begin
            modelEdge++;
            if (l) loadHistory.push_back('{modelEdge, v, d});
        end
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b0, 16'($urandom), 4'($urandom));
    endtask

    task automatic waitFrameDone();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3 * FRAME && !seen; i++) begin
            idle(1);
            if (frameDone === 1'b1) seen = 1'b1;
        end
        if (!seen) checkValue("frame_done timeout", 32'(0), 32'(1));
    endtask

    // Entered on the frame_done cycle; walks the whole frame digit by digit.
    task automatic checkFrame(input string tag, input logic [3:0][6:0] expSeg,
                              input logic [3:0] expDp);
        int d;
        for (int j = 0; j < FRAME; j++) begin
            if (j > 0) idle(1);
            d = j / SCAN_DIV;
            checkValue($sformatf("%s dig_en j=%0d", tag, j), 32'(digEn), 32'(4'(~(4'b0001 << d))));
            checkValue($sformatf("%s seg j=%0d", tag, j), 32'(seg), 32'(expSeg[d]));
            checkValue($sformatf("%s dp j=%0d", tag, j), 32'(dp), 32'(expDp[d]));
            checkValue($sformatf("%s frame_done j=%0d", tag, j), 32'(frameDone), 32'(j == 0));
        end
    endtask

    initial begin
        logic [15:0] rv;
        for (int i = 0; i < 16; i++) glyphRef[i] = segmentsFromName(glyphNames[i]);

        vecs[0] = '{16'h12AF, 4'b0000, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1111};
        vecs[1] = '{16'h0005, 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'b1110};
        vecs[2] = '{16'h0000, 4'b1000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0111};
        vecs[3] = '{16'h0B0C, 4'b0100, {7'h7F, 7'h03, 7'h40, 7'h46}, 4'b1011};
        vecs[4] = '{16'h8E6D, 4'b1111, {7'h00, 7'h06, 7'h02, 7'h21}, 4'b0000};
        vecs[5] = '{16'h0907, 4'b0010, {7'h7F, 7'h18, 7'h40, 7'h78}, 4'b1101};

        // Reset held three cycles, then the first live cycle shows digit 0.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
            checkValue("reset seg", 32'(seg), 32'(7'h7F));
            checkValue("reset dp", 32'(dp), 32'(1'b1));
            checkValue("reset dig_en", 32'(digEn), 32'(4'hF));
            checkValue("reset frame_done", 32'(frameDone), 32'(1'b0));
        end
        idle(1);
        checkValue("post-reset dig_en", 32'(digEn), 32'(4'hE));
        checkValue("post-reset seg", 32'(seg), 32'(7'h40));

        for (int v = 0; v < NUM_VECS; v++) begin
            applyStimulus(1'b0, 1'b1, vecs[v].value, vecs[v].dpIn);
            waitFrameDone();
            checkFrame($sformatf("vec%0d", v), vecs[v].expSeg, vecs[v].expDp);
        end

        // Two loads inside one frame: current frame untouched, last one wins.
        waitFrameDone();
        for (int j = 1; j < FRAME; j++) begin
            if (j == 5) applyStimulus(1'b0, 1'b1, 16'h1111, 4'h0);
            else if (j == 9) applyStimulus(1'b0, 1'b1, 16'h2222, 4'h0);
            else idle(1);
            checkValue($sformatf("tear-free seg j=%0d", j), 32'(seg),
                       32'(vecs[NUM_VECS-1].expSeg[j / SCAN_DIV]));
        end
        waitFrameDone();
        checkFrame("tear-free next", {4{7'h24}}, 4'b1111);

        // Load on the boundary cycle overrides an older pending load.
        waitFrameDone();
        idle(3);
        applyStimulus(1'b0, 1'b1, 16'h7777, 4'h0);
        for (int g = 0; g < FRAME && ((modelEdge + 1) % FRAME) != 0; g++) idle(1);
        applyStimulus(1'b0, 1'b1, 16'h3333, 4'h0);
        waitFrameDone();
        checkFrame("collision", {4{7'h30}}, 4'b1111);
        waitFrameDone();
        checkFrame("collision again", {4{7'h30}}, 4'b1111);

        // Reset with a load pending: the pending value must never appear.
        idle(4);
        applyStimulus(1'b0, 1'b1, 16'h9999, 4'hF);
        idle(2);
        applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
        applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
        waitFrameDone();
        checkFrame("after reset", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111);
        waitFrameDone();
        checkFrame("after reset 2", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111);

        // Randomized traffic, including occasional resets, against the model.
        for (int i = 0; i < 1500; i++) begin
            rv = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 3)));
            if ($urandom_range(0, 199) == 0)
                applyStimulus(1'b1, 1'b0, rv, 4'($urandom));
            else
                applyStimulus(1'b0, $urandom_range(0, 7) == 0, rv, 4'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sevseg_scan_driver.md
# sevseg_scan_driver

Multiplexed N-digit seven-segment display driver, the parametrised successor to the single-digit hex decoder. Holds an N-nibble hex value, time-multiplexes one digit at a time onto a shared segment bus with a one-hot digit enable, and supports leading-zero blanking, per-digit decimal points and tear-free updates committed only at frame boundaries. Sits between the clock divider / counter logic and the board's display pins.

## Interface
- NUM_DIGITS, 4, digits scanned (1..8)
- SCAN_DIV, 50000, clk cycles each digit is held (>=2)
- SEG_ACTIVE_LOW, 1, 1: lit segment/dp driven 0
- DIG_ACTIVE_LOW, 1, 1: enabled digit driven 0
- LZ_BLANK, 1, 1: enable leading-zero blanking

- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- load  in  1  request to latch value/dp_in
- value  in  4*NUM_DIGITS  hex digits, nibble k = digit k, digit 0 least significant
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
- seg  out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
- dp  out  1  decimal point, polarity per SEG_ACTIVE_LOW
- dig_en  out  NUM_DIGITS  one-hot digit enable, polarity per DIG_ACTIVE_LOW
- frame_done  out  1  one-cycle pulse when scan wraps to digit 0

## Operation
- Registers: prescaler (0..SCAN_DIV-1), digit index (0..NUM_DIGITS-1), shadow value/dp, display value/dp, pending flag, output registers.
- Prescaler increments every cycle; at SCAN_DIV-1 it wraps to 0 and index advances; index NUM_DIGITS-1 wraps to 0 (frame boundary).
- load=1: shadow <= value/dp_in, pending <= 1. Load while pending: last write wins.
- Frame boundary with pending=1: display <= shadow, pending <= 0.
- Load in the same cycle as the boundary: display <= value/dp_in directly, pending <= 0.
- Glyphs (active-high a..g): 0 abcdef, 1 bc, 2 abdeg, 3 abcdg, 4 bcfg, 5 acdfg, 6 acdefg, 7 abc, 8 all, 9 abcfg, A abcefg, b cdefg, C adef, d bcdeg, E adefg, F aefg.
- Blanking (LZ_BLANK=1): digit k>0 shows all segments off if nibbles k..NUM_DIGITS-1 are all zero; digit 0 is never blanked; dp unaffected by blanking.
- dig_en asserts only the current index; never zero-hot or multi-hot outside reset.

## Timing
- Reset (synchronous, next edge): prescaler 0, index 0, shadow/display 0, pending 0, frame_done 0; seg and dp off, dig_en all inactive.
- First cycle after rst deasserts: outputs register digit 0 of display (glyph 0) one edge later; output latency is 1 cycle from index/display change.
- Each digit enabled for exactly SCAN_DIV cycles; frame = NUM_DIGITS*SCAN_DIV cycles.
- frame_done high for one cycle, coincident with dig_en switching to digit 0.
- Load to visible: at most one frame + 1 cycle; value never changes mid-frame.
- rst mid-frame or with pending set: all state cleared, pending load discarded.

## Structure
- Package sevseg_pkg: SEG_W = 7, segment bit indices A..G, 16-entry active-high glyph constant array.
- Sub-module sevseg_glyph: combinational 4-bit hex -> 7-bit active-high segments; polarity inversion done in sevseg_scan_driver's output register only.

## Test plan
- Reset: NUM_DIGITS=4, SCAN_DIV=4, hold rst 3 cycles -> seg=7'h7F, dp=1, dig_en=4'hF throughout; first post-reset cycle shows dig_en=4'hE, seg=glyph 0.
- Scan: load value=16'h12AF once -> after next boundary each digit held 4 cycles in order 0..3; digit 0 seg = F, digit 3 seg = 1; frame_done every 16 cycles.
- Blanking: value=16'h0005, LZ_BLANK=1 -> digits 3,2,1 all-off, digit 0 shows 5; value=16'h0000 -> digit 0 shows 0.
- Tear-free: load 16'h1111 mid-frame then 16'h2222 before boundary -> current frame unchanged, next frame all digits 2.
- Boundary collision: assert load with value=16'h3333 on the frame_done cycle -> that frame shows 3333, pending stays 0.
- Reset mid-operation: load pending, assert rst -> next frame shows 0 with blanking, pending load never appears.
